// File: rtl/atm_txn_controller.sv
// ATM transaction sequencer: card/PIN gating of deposit and withdraw requests,
// balance register ownership, and arbitration of simultaneous requests.
module atm_txn_controller #(
  parameter int          BAL_W     = 8,
  parameter int          INIT_BAL  = 50,
  parameter int          STEP      = 10,
  parameter logic [11:0] PIN_CODE  = 12'h123,
  parameter int          MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [3:0]       pin_digit,
  input  logic             pin_valid,
  input  logic             dep_pulse,
  input  logic             wd_pulse,
  input  logic             done_btn,
  output logic [BAL_W-1:0] balance,
  output logic [1:0]       state,
  output logic             dispense,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PIN    = 2'd1,
    ACTIVE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [BAL_W:0]   STEP_X    = (BAL_W + 1)'(STEP);
  localparam logic [BAL_W-1:0] INIT_V    = BAL_W'(INIT_BAL);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [BAL_W-1:0] bal_d;
  logic             disp_d, err_d;
  logic [1:0]       code_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [11:0]      shift_q, shift_d;
  logic [TRY_W-1:0] tries_q, tries_d;

  logic [BAL_W:0]   dep_sum, wd_diff;
  logic             dep_ok, wd_ok;
  logic [11:0]      shifted;
  logic [TRY_W-1:0] tries_inc;

  // One extra bit of headroom so overflow shows up as the carry bit.
  assign dep_sum   = {1'b0, balance} + STEP_X;
  assign wd_diff   = {1'b0, balance} - STEP_X;
  assign dep_ok    = ~dep_sum[BAL_W];
  assign wd_ok     = ({1'b0, balance} >= STEP_X);
  assign shifted   = {shift_q[7:0], pin_digit};
  assign tries_inc = tries_q + 1'b1;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    bal_d   = balance;
    disp_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tries_d = tries_q;
    case (state_q)
      IDLE: begin
        if (card_in) begin
          state_d = PIN;
          cnt_d   = 2'd0;
          shift_d = 12'd0;
        end
      end
      PIN: begin
        if (!card_in) begin
          state_d = IDLE;
        end else if (pin_valid) begin
          shift_d = shifted;
          if (cnt_q == 2'd2) begin
            cnt_d = 2'd0;
            if (shifted == PIN_CODE) begin
              state_d = ACTIVE;
              tries_d = '0;
            end else begin
              err_d   = 1'b1;
              code_d  = 2'd1;
              tries_d = tries_inc;
              if (tries_inc == TRY_LIMIT) state_d = LOCKED;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ACTIVE: begin
        // Card removal wins over everything, including same-cycle requests.
        if (!card_in) begin
          state_d = IDLE;
        end else begin
          if (dep_pulse) begin
            if (dep_ok) begin
              bal_d = dep_sum[BAL_W-1:0];
            end else begin
              err_d  = 1'b1;
              code_d = 2'd3;
            end
            if (wd_pulse) begin
              err_d  = 1'b1;
              code_d = 2'd3;
            end
          end else if (wd_pulse) begin
            if (wd_ok) begin
              bal_d  = wd_diff[BAL_W-1:0];
              disp_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = 2'd2;
            end
          end
          if (done_btn) state_d = IDLE;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      balance  <= INIT_V;
      dispense <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      cnt_q    <= 2'd0;
      shift_q  <= 12'd0;
      tries_q  <= '0;
    end else begin
      state_q  <= state_d;
      balance  <= bal_d;
      dispense <= disp_d;
      err      <= err_d;
      err_code <= code_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tries_q  <= tries_d;
    end
  end

endmodule

// File: tb/tb_atm_txn_controller.sv
// Scoreboard bench for atm_txn_controller: directed vectors push expected
// outputs into a queue, a monitor pops and compares one cycle later.
module tb_atm_txn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       card_in;
  logic [3:0] pin_digit;
  logic       pin_valid;
  logic       dep_pulse;
  logic       wd_pulse;
  logic       done_btn;
  logic [7:0] balance;
  logic [1:0] state;
  logic       dispense;
  logic       err;
  logic [1:0] err_code;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] bal;
    logic       disp;
    logic       err;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  logic armed  = 1'b0;

  atm_txn_controller dut (
    .clk       (clk),
    .reset     (reset),
    .card_in   (card_in),
    .pin_digit (pin_digit),
    .pin_valid (pin_valid),
    .dep_pulse (dep_pulse),
    .wd_pulse  (wd_pulse),
    .done_btn  (done_btn),
    .balance   (balance),
    .state     (state),
    .dispense  (dispense),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the expected result.
  task automatic applyStimulus(input logic rst, input logic card, input logic [3:0] dig,
                               input logic pv, input logic dep, input logic wd, input logic done,
                               input logic [1:0] es, input logic [7:0] eb, input logic ed,
                               input logic ee, input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    card_in   = card;
    pin_digit = dig;
    pin_valid = pv;
    dep_pulse = dep;
    wd_pulse  = wd;
    done_btn  = done;
    e.st   = es;
    e.bal  = eb;
    e.disp = ed;
    e.err  = ee;
    e.code = ec;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic enterPin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [1:0] prior_code, input logic [7:0] bal,
                          input logic [1:0] final_st, input logic final_err,
                          input logic [1:0] final_code);
    applyStimulus(1'b0, 1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, bal, 1'b0, 1'b0, prior_code);
    applyStimulus(1'b0, 1'b1, b, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, bal, 1'b0, 1'b0, prior_code);
    applyStimulus(1'b0, 1'b1, c, 1'b1, 1'b0, 1'b0, 1'b0, final_st, bal, 1'b0, final_err, final_code);
  endtask

  // Monitor: every cycle with a queued expectation is compared; any pulse with
  // nothing queued is an unexpected output.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("state",    8'(state),    8'(mon_e.st));
        checkOutput("balance",  balance,      mon_e.bal);
        checkOutput("dispense", 8'(dispense), 8'(mon_e.disp));
        checkOutput("err",      8'(err),      8'(mon_e.err));
        checkOutput("err_code", 8'(err_code), 8'(mon_e.code));
      end else if (armed) begin
        checkOutput("idle_pulse", 8'({dispense, err}), 8'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; card_in = 1'b0; pin_digit = 4'd0; pin_valid = 1'b0;
    dep_pulse = 1'b0; wd_pulse = 1'b0; done_btn = 1'b0;

    // Reset, card in, good PIN (deposit during PIN entry ignored)
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd50, 0, 0, 2'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd50, 0, 0, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd50, 0, 0, 2'd0);
    applyStimulus(0, 1, 4'd1, 1, 1, 0, 0, 2'd1, 8'd50, 0, 0, 2'd0);
    applyStimulus(0, 1, 4'd2, 1, 0, 0, 0, 2'd1, 8'd50, 0, 0, 2'd0);
    applyStimulus(0, 1, 4'd3, 1, 0, 0, 0, 2'd2, 8'd50, 0, 0, 2'd0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 2'd2, 8'd60, 0, 0, 2'd0);
    for (int i = 1; i <= 6; i++)
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 2'd2, 8'(60 - 10 * i), 1, 0, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 2'd2, 8'd0, 0, 1, 2'd2);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 2'd2, 8'd10, 0, 0, 2'd2);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 2'd0, 8'd20, 0, 0, 2'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd20, 0, 0, 2'd2);

    // Three wrong PINs lock the machine
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd20, 0, 0, 2'd2);
    enterPin(4'd1, 4'd2, 4'd4, 2'd2, 8'd20, 2'd1, 1, 2'd1);
    enterPin(4'd1, 4'd2, 4'd4, 2'd1, 8'd20, 2'd1, 1, 2'd1);
    enterPin(4'd1, 4'd2, 4'd4, 2'd1, 8'd20, 2'd3, 1, 2'd1);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 2'd3, 8'd20, 0, 0, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd3, 8'd20, 0, 0, 2'd1);
    applyStimulus(0, 1, 4'd1, 1, 0, 0, 1, 2'd3, 8'd20, 0, 0, 2'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd50, 0, 0, 2'd0);

    // Fill to 250, overflow reject, drain to 50, simultaneous dep+wd
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd50, 0, 0, 2'd0);
    enterPin(4'd1, 4'd2, 4'd3, 2'd0, 8'd50, 2'd2, 0, 2'd0);
    for (int i = 1; i <= 20; i++)
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 2'd2, 8'(50 + 10 * i), 0, 0, 2'd0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 2'd2, 8'd250, 0, 1, 2'd3);
    for (int i = 1; i <= 20; i++)
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 2'd2, 8'(250 - 10 * i), 1, 0, 2'd3);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 2'd2, 8'd60, 0, 1, 2'd3);

    // Card pulled with a withdraw in the same cycle
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 2'd0, 8'd60, 0, 0, 2'd3);

    // Tries survive card removal but clear on a correct PIN
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd60, 0, 0, 2'd3);
    enterPin(4'd1, 4'd2, 4'd4, 2'd3, 8'd60, 2'd1, 1, 2'd1);
    enterPin(4'd1, 4'd2, 4'd4, 2'd1, 8'd60, 2'd1, 1, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd60, 0, 0, 2'd1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd60, 0, 0, 2'd1);
    enterPin(4'd1, 4'd2, 4'd3, 2'd1, 8'd60, 2'd2, 0, 2'd1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 2'd0, 8'd60, 0, 0, 2'd1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'd1, 8'd60, 0, 0, 2'd1);
    enterPin(4'd1, 4'd2, 4'd4, 2'd1, 8'd60, 2'd1, 1, 2'd1);
    enterPin(4'd1, 4'd2, 4'd3, 2'd1, 8'd60, 2'd2, 0, 2'd1);

    @(negedge clk);
    card_in = 1'b0; pin_valid = 1'b0; dep_pulse = 1'b0; wd_pulse = 1'b0; done_btn = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
